udt_rx_classifier: RTL and testbench
====================================

Name: udt_rx_classifier

Overview:
- Sits directly upstream of udt_core's UDT receive logic and consumes the UDP stack's RX AXI-Stream (udp_rx_*), 64-bit beats.
- Parses the 16-byte UDT header and filters on the destination UDP port.
- Data packets: the payload is forwarded on a registered AXI-Stream with the sequence number as sideband.
- Control packets: the header fields plus the first 8 bytes of control info are presented on a single-entry control channel.

Parameters:
- PORT, 16'd10086, UDT listening port; packets with any other udp_rx_port_dest are dropped.
- DROP_CNT_W, 16, width of the saturating drop counter.

Ports:
- core_clk  in  1  block clock.
- core_rst  in  1  asynchronous, active-high reset.
- udp_rx_tvalid  in  1  UDP RX beat valid.
- udp_rx_tready  out  1  UDP RX beat ready.
- udp_rx_tlast  in  1  last beat of the datagram.
- udp_rx_tkeep  in  8  byte enables; bit i qualifies tdata[8i+7:8i].
- udp_rx_tdata  in  64  payload; the first wire byte is in tdata[7:0].
- udp_rx_ip_src  in  32  peer IP; stable for the whole datagram.
- udp_rx_port_src  in  16  peer port; stable for the whole datagram.
- udp_rx_port_dest  in  16  destination port; stable for the whole datagram.
- m_data_tvalid  out  1  payload beat valid.
- m_data_tready  in  1  payload beat ready.
- m_data_tdata  out  64  payload beat.
- m_data_tkeep  out  8  payload byte enables.
- m_data_tlast  out  1  last payload beat.
- m_data_seq  out  31  packet sequence number; held for the whole packet.
- ctrl_valid  out  1  control record valid.
- ctrl_ready  in  1  control record accepted.
- ctrl_type  out  15  header word0[30:16].
- ctrl_addinfo  out  32  header word1.
- ctrl_timestamp  out  32  header word2.
- ctrl_sock_id  out  32  header word3.
- ctrl_info  out  64  bytes 16..23 of the datagram, byte-swapped per 32-bit word.
- ctrl_info_present  out  1  ctrl_info holds a full 8 bytes.
- ctrl_peer_ip  out  32  peer IP of the control packet.
- ctrl_peer_port  out  16  peer port of the control packet.
- cfg_sock_id  in  32  local socket ID; used only with the optional feature.
- drop_cnt  out  DROP_CNT_W  count of dropped datagrams; saturating.

Behaviour:
- Reset:
  - state=HDR0; all valids 0; all data, sideband and ctrl fields 0; drop_cnt 0.
  - Reset mid-packet abandons the packet; the remaining input beats are accepted as a fresh datagram (upstream is reset together).
- Header layout:
  - Header words are big-endian: wordN = {b0,b1,b2,b3}, with b0 in the lowest tkeep lane.
  - Beat0 = word0 in bytes 0-3, word1 in bytes 4-7. Beat1 = word2, word3.
  - word0[31] = 0 marks data (seq = word0[30:0]); 1 marks control.
- States: HDR0, HDR1, DATA, CTRL_INFO, CTRL_DRAIN, CTRL_HOLD, DROP.
- HDR0:
  - udp_rx_tready = !ctrl_valid; a pending control record stalls all input.
  - On a beat, capture word0 and word1.
  - Go to DROP if udp_rx_port_dest != PORT, or if tlast (short packet, counted, no move). Otherwise go to HDR1.
- HDR1:
  - tready = 1; capture word2 and word3.
  - tlast on this beat, data packet: drop and count (header-only). Control packet: ctrl_info_present = 0, go to CTRL_HOLD.
  - Otherwise: data goes to DATA with m_data_seq loaded; control goes to CTRL_INFO.
- DATA:
  - Single-stage register slice; latency is 1 cycle from input beat to m_data_tvalid.
  - udp_rx_tready = !m_data_tvalid || m_data_tready. tdata, tkeep and tlast are copied unchanged.
  - On accepting tlast, go to HDR0.
  - No bubble is required between packets; a HDR0 beat may be accepted while the last payload beat is still held.
- CTRL_INFO:
  - tready = 1; capture beat2 into ctrl_info.
  - ctrl_info_present = (tkeep == 8'hFF).
  - On tlast go to CTRL_HOLD; otherwise go to CTRL_DRAIN.
- CTRL_DRAIN: tready = 1; discard beats; on tlast go to CTRL_HOLD.
- CTRL_HOLD:
  - ctrl_valid = 1 with peer IP and port as latched at HDR0; tready = 0.
  - On ctrl_ready, go to HDR0 and deassert ctrl_valid on the next cycle.
  - ctrl_valid and the record fields are stable until accepted.
- DROP: tready = 1; discard beats until tlast, then go to HDR0.
- drop_cnt:
  - Increments by 1 once per dropped datagram, at the beat that decides the drop.
  - Saturates at all-ones; never wraps.
- No division of input beats; the payload keeps the input's 8-byte alignment because the header is exactly 2 beats.

Optional Feature:
- Macro: UDT_RX_SOCKID_FILTER_EN.
- Defined: in HDR1, if word3 != cfg_sock_id and cfg_sock_id != 0, the packet goes to DROP (counted), for both data and control. cfg_sock_id == 0 accepts all packets.
- Undefined: cfg_sock_id is ignored and no socket-ID comparison logic is built.

Test Plan:
- Data packet, port 10086, word0 = 0x0000_0123, 4 payload beats (last tkeep 0x0F) with m_data_tready = 1 -> 4 beats out, each 1 cycle after input, m_data_seq = 0x123, last beat tkeep 0x0F with tlast, drop_cnt = 0.
- Control packet, word0 = 0x8002_0000, 3 beats total with beat2 tkeep 0xFF -> ctrl_valid with ctrl_type = 0x0002 and ctrl_info_present = 1; with ctrl_ready held 0 for 10 cycles, udp_rx_tready stays 0 and the fields stay stable.
- Datagram to port 5000, 5 beats -> all beats accepted, no output, drop_cnt = 1; a 1-beat datagram (tlast on beat0) -> drop_cnt = 2.
- Data payload with m_data_tready toggling 1/0 every cycle -> no beat lost or duplicated; data is compared against a scoreboard.
- Back-to-back data packets with zero idle cycles, then 65540 short packets -> seq updates per packet and drop_cnt saturates at 0xFFFF.
- With UDT_RX_SOCKID_FILTER_EN defined and cfg_sock_id = 7: packet with word3 = 7 is passed; word3 = 8 is dropped and counted; with cfg_sock_id = 0, both are passed.

Source files
------------

// File: rtl/udt_rx_classifier.sv
`default_nettype none
// ============================================================================
// Module      : udt_rx_classifier
// Description : Front end for the UDT receive path. Consumes the UDP RX
//               AXI-Stream (64-bit beats), parses the 16-byte UDT header and
//               drops datagrams that are not addressed to PORT.
//               - Data packets: the payload goes out on a one-stage register
//                 slice (m_data_*), with the 31-bit sequence number on
//                 m_data_seq.
//               - Control packets: the header fields and the first 8 bytes
//                 of control info are presented as one record (ctrl_*).
//               - drop_cnt counts dropped datagrams and saturates.
// Ports       : core_clk/core_rst (async, active-high reset)
//               udp_rx_*  : UDP RX stream in, plus peer IP/port sideband
//               m_data_*  : payload stream out, plus m_data_seq
//               ctrl_*    : control record with ctrl_valid/ctrl_ready
//               cfg_sock_id, drop_cnt
// Options     : `define UDT_RX_SOCKID_FILTER_EN to drop packets whose header
//               socket ID differs from a non-zero cfg_sock_id.
// Revision    : 1.0 - initial release
// ============================================================================
module udt_rx_classifier #(
    parameter logic [15:0] PORT       = 16'd10086,
    parameter int          DROP_CNT_W = 16
) (
    input  logic                  core_clk,
    input  logic                  core_rst,
    input  logic                  udp_rx_tvalid,
    output logic                  udp_rx_tready,
    input  logic                  udp_rx_tlast,
    input  logic [7:0]            udp_rx_tkeep,
    input  logic [63:0]           udp_rx_tdata,
    input  logic [31:0]           udp_rx_ip_src,
    input  logic [15:0]           udp_rx_port_src,
    input  logic [15:0]           udp_rx_port_dest,
    output logic                  m_data_tvalid,
    input  logic                  m_data_tready,
    output logic [63:0]           m_data_tdata,
    output logic [7:0]            m_data_tkeep,
    output logic                  m_data_tlast,
    output logic [30:0]           m_data_seq,
    output logic                  ctrl_valid,
    input  logic                  ctrl_ready,
    output logic [14:0]           ctrl_type,
    output logic [31:0]           ctrl_addinfo,
    output logic [31:0]           ctrl_timestamp,
    output logic [31:0]           ctrl_sock_id,
    output logic [63:0]           ctrl_info,
    output logic                  ctrl_info_present,
    output logic [31:0]           ctrl_peer_ip,
    output logic [15:0]           ctrl_peer_port,
    input  logic [31:0]           cfg_sock_id,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [2:0] c_ST_HDR0       = 3'd0;
    localparam logic [2:0] c_ST_HDR1       = 3'd1;
    localparam logic [2:0] c_ST_DATA       = 3'd2;
    localparam logic [2:0] c_ST_CTRL_INFO  = 3'd3;
    localparam logic [2:0] c_ST_CTRL_DRAIN = 3'd4;
    localparam logic [2:0] c_ST_CTRL_HOLD  = 3'd5;
    localparam logic [2:0] c_ST_DROP       = 3'd6;

    localparam logic [DROP_CNT_W-1:0] c_DROP_ONE = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    // Header words are big-endian on the wire while the first wire byte sits
    // in the lowest lane, so each 32-bit half of a beat is byte-reversed.
    function automatic logic [31:0] f_bswap32(input logic [31:0] v);
        f_bswap32 = {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    logic [2:0]            r_state;
    logic [31:0]           r_w0;
    logic [31:0]           r_w1;
    logic [31:0]           r_w2;
    logic [31:0]           r_w3;
    logic [31:0]           r_peer_ip;
    logic [15:0]           r_peer_port;
    logic [63:0]           r_ctrl_info;
    logic                  r_info_present;
    logic                  r_ctrl_valid;
    logic [30:0]           r_seq;
    logic                  r_m_valid;
    logic [63:0]           r_m_data;
    logic [7:0]            r_m_keep;
    logic                  r_m_last;
    logic [30:0]           r_m_seq;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic        w_tready;
    logic        w_beat;
    logic        w_drop;
    logic        w_sock_reject;
    logic [31:0] w_lo_word;
    logic [31:0] w_hi_word;

    assign w_lo_word = f_bswap32(udp_rx_tdata[31:0]);
    assign w_hi_word = f_bswap32(udp_rx_tdata[63:32]);

`ifdef UDT_RX_SOCKID_FILTER_EN
    // w_hi_word on the HDR1 beat is word3 (the destination socket ID).
    assign w_sock_reject = (w_hi_word != cfg_sock_id) && (cfg_sock_id != 32'd0);
`else
    logic w_unused_sock;
    assign w_unused_sock = ^cfg_sock_id;
    assign w_sock_reject = 1'b0;
`endif

    always_comb begin
        w_tready = 1'b1;
        case (r_state)
            c_ST_HDR0:      w_tready = !r_ctrl_valid;
            c_ST_DATA:      w_tready = !r_m_valid || m_data_tready;
            c_ST_CTRL_HOLD: w_tready = 1'b0;
            default:        w_tready = 1'b1;
        endcase
    end

    assign w_beat = udp_rx_tvalid && w_tready;

    // The drop decision is made on the beat that settles the packet's fate.
    always_comb begin
        w_drop = 1'b0;
        if (w_beat) begin
            if (r_state == c_ST_HDR0) begin
                w_drop = udp_rx_tlast || (udp_rx_port_dest != PORT);
            end else if (r_state == c_ST_HDR1) begin
                w_drop = w_sock_reject || (!r_w0[31] && udp_rx_tlast);
            end
        end
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_state        <= c_ST_HDR0;
            r_w0           <= '0;
            r_w1           <= '0;
            r_w2           <= '0;
            r_w3           <= '0;
            r_peer_ip      <= '0;
            r_peer_port    <= '0;
            r_ctrl_info    <= '0;
            r_info_present <= 1'b0;
            r_ctrl_valid   <= 1'b0;
            r_seq          <= '0;
            r_m_valid      <= 1'b0;
            r_m_data       <= '0;
            r_m_keep       <= '0;
            r_m_last       <= 1'b0;
            r_m_seq        <= '0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_drop && !(&r_drop_cnt)) begin
                r_drop_cnt <= r_drop_cnt + c_DROP_ONE;
            end

            // Output slice drains independently of the parser state so the
            // next header can be accepted while the last payload beat waits.
            if (r_state == c_ST_DATA && w_beat) begin
                r_m_valid <= 1'b1;
                r_m_data  <= udp_rx_tdata;
                r_m_keep  <= udp_rx_tkeep;
                r_m_last  <= udp_rx_tlast;
                r_m_seq   <= r_seq;
            end else if (m_data_tready) begin
                r_m_valid <= 1'b0;
            end

            case (r_state)
                c_ST_HDR0: begin
                    if (w_beat) begin
                        r_w0        <= w_lo_word;
                        r_w1        <= w_hi_word;
                        r_peer_ip   <= udp_rx_ip_src;
                        r_peer_port <= udp_rx_port_src;
                        if (udp_rx_tlast) begin
                            r_state <= c_ST_HDR0;
                        end else if (udp_rx_port_dest != PORT) begin
                            r_state <= c_ST_DROP;
                        end else begin
                            r_state <= c_ST_HDR1;
                        end
                    end
                end
                c_ST_HDR1: begin
                    if (w_beat) begin
                        r_w2 <= w_lo_word;
                        r_w3 <= w_hi_word;
                        if (w_sock_reject) begin
                            r_state <= udp_rx_tlast ? c_ST_HDR0 : c_ST_DROP;
                        end else if (!r_w0[31]) begin
                            if (udp_rx_tlast) begin
                                r_state <= c_ST_HDR0;
                            end else begin
                                r_seq   <= r_w0[30:0];
                                r_state <= c_ST_DATA;
                            end
                        end else if (udp_rx_tlast) begin
                            r_info_present <= 1'b0;
                            r_ctrl_valid   <= 1'b1;
                            r_state        <= c_ST_CTRL_HOLD;
                        end else begin
                            r_state <= c_ST_CTRL_INFO;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (w_beat && udp_rx_tlast) begin
                        r_state <= c_ST_HDR0;
                    end
                end
                c_ST_CTRL_INFO: begin
                    if (w_beat) begin
                        r_ctrl_info    <= {w_hi_word, w_lo_word};
                        r_info_present <= (udp_rx_tkeep == 8'hFF);
                        if (udp_rx_tlast) begin
                            r_ctrl_valid <= 1'b1;
                            r_state      <= c_ST_CTRL_HOLD;
                        end else begin
                            r_state <= c_ST_CTRL_DRAIN;
                        end
                    end
                end
                c_ST_CTRL_DRAIN: begin
                    if (w_beat && udp_rx_tlast) begin
                        r_ctrl_valid <= 1'b1;
                        r_state      <= c_ST_CTRL_HOLD;
                    end
                end
                c_ST_CTRL_HOLD: begin
                    if (ctrl_ready) begin
                        r_ctrl_valid <= 1'b0;
                        r_state      <= c_ST_HDR0;
                    end
                end
                c_ST_DROP: begin
                    if (w_beat && udp_rx_tlast) begin
                        r_state <= c_ST_HDR0;
                    end
                end
                default: r_state <= c_ST_HDR0;
            endcase
        end
    end

    assign udp_rx_tready     = w_tready;
    assign m_data_tvalid     = r_m_valid;
    assign m_data_tdata      = r_m_data;
    assign m_data_tkeep      = r_m_keep;
    assign m_data_tlast      = r_m_last;
    assign m_data_seq        = r_m_seq;
    assign ctrl_valid        = r_ctrl_valid;
    assign ctrl_type         = r_w0[30:16];
    assign ctrl_addinfo      = r_w1;
    assign ctrl_timestamp    = r_w2;
    assign ctrl_sock_id      = r_w3;
    assign ctrl_info         = r_ctrl_info;
    assign ctrl_info_present = r_info_present;
    assign ctrl_peer_ip      = r_peer_ip;
    assign ctrl_peer_port    = r_peer_port;
    assign drop_cnt          = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_udt_rx_classifier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_udt_rx_classifier
// Description : Scoreboard bench for udt_rx_classifier. Directed packets are
//               driven on the UDP RX stream; expected payload beats and
//               control records are queued and popped by a monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_udt_rx_classifier;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        udp_rx_tvalid = 1'b0;
    logic        udp_rx_tready;
    logic        udp_rx_tlast = 1'b0;
    logic [7:0]  udp_rx_tkeep = 8'h00;
    logic [63:0] udp_rx_tdata = 64'd0;
    logic [31:0] udp_rx_ip_src = 32'h0A00_0001;
    logic [15:0] udp_rx_port_src = 16'd9000;
    logic [15:0] udp_rx_port_dest = 16'd10086;
    logic        m_data_tvalid;
    logic        m_data_tready = 1'b1;
    logic [63:0] m_data_tdata;
    logic [7:0]  m_data_tkeep;
    logic        m_data_tlast;
    logic [30:0] m_data_seq;
    logic        ctrl_valid;
    logic        ctrl_ready = 1'b1;
    logic [14:0] ctrl_type;
    logic [31:0] ctrl_addinfo;
    logic [31:0] ctrl_timestamp;
    logic [31:0] ctrl_sock_id;
    logic [63:0] ctrl_info;
    logic        ctrl_info_present;
    logic [31:0] ctrl_peer_ip;
    logic [15:0] ctrl_peer_port;
    logic [31:0] cfg_sock_id = 32'd0;
    logic [15:0] drop_cnt;

    udt_rx_classifier dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .udp_rx_tvalid(udp_rx_tvalid), .udp_rx_tready(udp_rx_tready),
        .udp_rx_tlast(udp_rx_tlast), .udp_rx_tkeep(udp_rx_tkeep),
        .udp_rx_tdata(udp_rx_tdata), .udp_rx_ip_src(udp_rx_ip_src),
        .udp_rx_port_src(udp_rx_port_src), .udp_rx_port_dest(udp_rx_port_dest),
        .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
        .m_data_tdata(m_data_tdata), .m_data_tkeep(m_data_tkeep),
        .m_data_tlast(m_data_tlast), .m_data_seq(m_data_seq),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .ctrl_type(ctrl_type), .ctrl_addinfo(ctrl_addinfo),
        .ctrl_timestamp(ctrl_timestamp), .ctrl_sock_id(ctrl_sock_id),
        .ctrl_info(ctrl_info), .ctrl_info_present(ctrl_info_present),
        .ctrl_peer_ip(ctrl_peer_ip), .ctrl_peer_port(ctrl_peer_port),
        .cfg_sock_id(cfg_sock_id), .drop_cnt(drop_cnt)
    );

    always #5 core_clk = ~core_clk;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [30:0] s;
        logic        lat;
        int          cyc;
    } beat_t;

    typedef struct {
        logic [14:0] ty;
        logic [31:0] ai;
        logic [31:0] ts;
        logic [31:0] sk;
        logic [63:0] info;
        logic        pr;
        logic [31:0] ip;
        logic [15:0] pt;
    } ctrl_t;

    beat_t exp_q[$];
    ctrl_t ctl_q[$];
    beat_t m_e;
    ctrl_t m_c;
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;
    int    exp_drop = 0;
    bit    tog_en = 1'b0;

    always @(posedge core_clk) cyc <= cyc + 1;

    always @(posedge core_clk) begin
        if (tog_en) begin
            #1 m_data_tready = ~m_data_tready;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Encode two big-endian header words into one beat (first wire byte in lane 0).
    function automatic logic [63:0] hbeat(input logic [31:0] a, input logic [31:0] b);
        hbeat = {b[7:0], b[15:8], b[23:16], b[31:24], a[7:0], a[15:8], a[23:16], a[31:24]};
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        int t;
        t = 0;
        udp_rx_tvalid = 1'b1;
        udp_rx_tdata  = d;
        udp_rx_tkeep  = k;
        udp_rx_tlast  = l;
        @(negedge core_clk);
        while (!udp_rx_tready) begin
            t++;
            if (t > 200) begin
                $display("FAIL send_beat_timeout: got tready=0 expected 1");
                $fatal(1, "input stalled");
            end
            @(negedge core_clk);
        end
        @(posedge core_clk);
        #1;
        udp_rx_tvalid = 1'b0;
    endtask

    task automatic send_data(input logic [15:0] port, input logic [30:0] seq,
                             input logic [31:0] w3, input int n, input logic [7:0] lastk,
                             input bit lat, input bit pass);
        beat_t e;
        logic [63:0] d;
        logic [7:0]  k;
        udp_rx_port_dest = port;
        send_beat(hbeat({1'b0, seq}, 32'hAAAA_0001), 8'hFF, 1'b0);
        send_beat(hbeat(32'h0000_0010, w3), 8'hFF, 1'b0);
        for (int i = 0; i < n; i++) begin
            d = {8'hA0 + 8'(i), seq[23:0], 32'h5A5A_0000 | 32'(i)};
            k = (i == n - 1) ? lastk : 8'hFF;
            send_beat(d, k, i == n - 1);
            if (pass) begin
                e.d = d; e.k = k; e.l = (i == n - 1); e.s = seq;
                e.lat = lat; e.cyc = cyc;
                exp_q.push_back(e);
            end
        end
    endtask

    always @(negedge core_clk) begin
        if (!core_rst && m_data_tvalid && m_data_tready) begin
            if (exp_q.size() == 0) begin
                chk("data_unexpected_beat", 64'd1, 64'd0);
            end else begin
                m_e = exp_q.pop_front();
                chk("data_tdata", m_data_tdata, m_e.d);
                chk("data_tkeep", 64'(m_data_tkeep), 64'(m_e.k));
                chk("data_tlast", 64'(m_data_tlast), 64'(m_e.l));
                chk("data_seq", 64'(m_data_seq), 64'(m_e.s));
                if (m_e.lat) chk("data_latency_cycle", 64'(cyc), 64'(m_e.cyc));
            end
        end
        if (!core_rst && ctrl_valid && ctrl_ready) begin
            if (ctl_q.size() == 0) begin
                chk("ctrl_unexpected_record", 64'd1, 64'd0);
            end else begin
                m_c = ctl_q.pop_front();
                chk("ctrl_type", 64'(ctrl_type), 64'(m_c.ty));
                chk("ctrl_addinfo", 64'(ctrl_addinfo), 64'(m_c.ai));
                chk("ctrl_timestamp", 64'(ctrl_timestamp), 64'(m_c.ts));
                chk("ctrl_sock_id", 64'(ctrl_sock_id), 64'(m_c.sk));
                chk("ctrl_info_present", 64'(ctrl_info_present), 64'(m_c.pr));
                if (m_c.pr) chk("ctrl_info", ctrl_info, m_c.info);
                chk("ctrl_peer_ip", 64'(ctrl_peer_ip), 64'(m_c.ip));
                chk("ctrl_peer_port", 64'(ctrl_peer_port), 64'(m_c.pt));
            end
        end
    end

    initial begin
        ctrl_t c;
        int t;
        repeat (3) @(posedge core_clk);
        #1 core_rst = 1'b0;

        // Reset state
        @(negedge core_clk);
        chk("rst_m_data_tvalid", 64'(m_data_tvalid), 64'd0);
        chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_m_data_seq", 64'(m_data_seq), 64'd0);
        chk("rst_ctrl_type", 64'(ctrl_type), 64'd0);
        chk("rst_udp_rx_tready", 64'(udp_rx_tready), 64'd1);
        @(posedge core_clk); #1;

        // Data packet, 4 payload beats, last tkeep 0x0F, 1-cycle latency
        send_data(16'd10086, 31'h123, 32'd5, 4, 8'h0F, 1'b1, 1'b1);
        repeat (2) @(posedge core_clk); #1;
        chk("t1_drop_cnt", 64'(drop_cnt), 64'd0);

        // Control packet with full info, held unaccepted for 10 cycles
        ctrl_ready = 1'b0;
        udp_rx_ip_src = 32'hC0A8_0102; udp_rx_port_src = 16'd4321;
        c.ty = 15'h0002; c.ai = 32'h1234_5678; c.ts = 32'h0BAD_F00D; c.sk = 32'd9;
        c.info = 64'h5566_7788_1122_3344; c.pr = 1'b1; c.ip = 32'hC0A8_0102; c.pt = 16'd4321;
        ctl_q.push_back(c);
        send_beat(hbeat(32'h8002_0000, 32'h1234_5678), 8'hFF, 1'b0);
        send_beat(hbeat(32'h0BAD_F00D, 32'd9), 8'hFF, 1'b0);
        udp_rx_ip_src = 32'hDEAD_BEEF; udp_rx_port_src = 16'd1;
        send_beat(64'h8877_6655_4433_2211, 8'hFF, 1'b1);
        t = 0;
        while (!ctrl_valid && t < 20) begin @(posedge core_clk); #1; t++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            chk("stall_ctrl_valid", 64'(ctrl_valid), 64'd1);
            chk("stall_udp_rx_tready", 64'(udp_rx_tready), 64'd0);
            chk("stall_ctrl_type", 64'(ctrl_type), 64'h2);
            chk("stall_ctrl_info", ctrl_info, 64'h5566_7788_1122_3344);
        end
        @(posedge core_clk); #1;
        ctrl_ready = 1'b1;
        @(posedge core_clk); #1;
        @(negedge core_clk);
        chk("ctrl_valid_after_accept", 64'(ctrl_valid), 64'd0);
        @(posedge core_clk); #1;

        // Header-only control packet: info not present
        c.ty = 15'h7FFF; c.ai = 32'h0000_0001; c.ts = 32'h0000_0002; c.sk = 32'h0000_0003;
        c.info = 64'd0; c.pr = 1'b0; c.ip = 32'hDEAD_BEEF; c.pt = 16'd1;
        ctl_q.push_back(c);
        send_beat(hbeat(32'hFFFF_0000, 32'h1), 8'hFF, 1'b0);
        send_beat(hbeat(32'h2, 32'h3), 8'hFF, 1'b1);
        // Control with partial info beat: not present
        c.ty = 15'h0005; c.ai = 32'h0; c.ts = 32'h0; c.sk = 32'h0; c.pr = 1'b0;
        ctl_q.push_back(c);
        send_beat(hbeat(32'h8005_0000, 32'h0), 8'hFF, 1'b0);
        send_beat(hbeat(32'h0, 32'h0), 8'hFF, 1'b0);
        send_beat(64'h0000_0000_AABB_CCDD, 8'h0F, 1'b1);
        // Control with full info followed by two drain beats
        c.ty = 15'h0006; c.ai = 32'h0000_00A1; c.ts = 32'h0000_00A2; c.sk = 32'h0000_00A3;
        c.info = 64'h0405_0607_0001_0203; c.pr = 1'b1;
        ctl_q.push_back(c);
        send_beat(hbeat(32'h8006_0000, 32'hA1), 8'hFF, 1'b0);
        send_beat(hbeat(32'hA2, 32'hA3), 8'hFF, 1'b0);
        send_beat(64'h0706_0504_0302_0100, 8'hFF, 1'b0);
        send_beat(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
        send_beat(64'hEEEE_EEEE_EEEE_EEEE, 8'h01, 1'b1);

        // Wrong port, 5 beats: all accepted, no output, one drop
        udp_rx_port_dest = 16'd5000;
        for (int i = 0; i < 5; i++) send_beat(64'h1111 * 64'(i + 1), 8'hFF, i == 4);
        exp_drop++;
        chk("drop_wrong_port", 64'(drop_cnt), 64'(exp_drop));
        // Single-beat datagram to the right port
        udp_rx_port_dest = 16'd10086;
        send_beat(hbeat(32'h0000_0042, 32'h0), 8'hFF, 1'b1);
        exp_drop++;
        chk("drop_short_pkt", 64'(drop_cnt), 64'(exp_drop));
        // Header-only data packet
        send_beat(hbeat(32'h0000_0042, 32'h0), 8'hFF, 1'b0);
        send_beat(hbeat(32'h0, 32'h0), 8'hFF, 1'b1);
        exp_drop++;
        chk("drop_hdr_only_data", 64'(drop_cnt), 64'(exp_drop));

`ifdef UDT_RX_SOCKID_FILTER_EN
        cfg_sock_id = 32'd7;
        send_data(16'd10086, 31'h700, 32'd7, 2, 8'hFF, 1'b0, 1'b1);
        send_data(16'd10086, 31'h701, 32'd8, 2, 8'hFF, 1'b0, 1'b0);
        exp_drop++;
        chk("sockid_mismatch_drop", 64'(drop_cnt), 64'(exp_drop));
        cfg_sock_id = 32'd0;
        send_data(16'd10086, 31'h702, 32'd7, 1, 8'hFF, 1'b0, 1'b1);
        send_data(16'd10086, 31'h703, 32'd8, 1, 8'hFF, 1'b0, 1'b1);
        chk("sockid_zero_no_drop", 64'(drop_cnt), 64'(exp_drop));
`endif

        // Payload under toggling m_data_tready, maximum sequence number
        tog_en = 1'b1;
        send_data(16'd10086, 31'h7FFF_FFFF, 32'd5, 6, 8'h01, 1'b0, 1'b1);
        t = 0;
        while (exp_q.size() != 0 && t < 50) begin @(posedge core_clk); #1; t++; end
        tog_en = 1'b0;
        #2 m_data_tready = 1'b1;
        @(posedge core_clk); #1;

        // Back-to-back data packets, zero idle cycles
        send_data(16'd10086, 31'h1, 32'd5, 2, 8'hFF, 1'b1, 1'b1);
        send_data(16'd10086, 31'h2, 32'd5, 3, 8'h3F, 1'b1, 1'b1);
        send_data(16'd10086, 31'h3, 32'd5, 1, 8'h80, 1'b1, 1'b1);

        // Short packets until the drop counter saturates
        for (int i = 0; i < 65540; i++) begin
            send_beat(64'(i), 8'hFF, 1'b1);
            if (exp_drop < 65535) exp_drop++;
            if ((i % 8192) == 0 || i == 65531 || i == 65539)
                chk("drop_cnt_saturation", 64'(drop_cnt), 64'(exp_drop));
        end
        chk("drop_cnt_saturated_ffff", 64'(drop_cnt), 64'hFFFF);

        t = 0;
        while ((exp_q.size() != 0 || ctl_q.size() != 0) && t < 50) begin
            @(posedge core_clk); #1; t++;
        end
        chk("data_queue_drained", 64'(exp_q.size()), 64'd0);
        chk("ctrl_queue_drained", 64'(ctl_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
